// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter
//   Arbitrates a CPU's instruction-fetch port and data port onto one shared
//   bus. Only one transaction is outstanding at a time. Every transaction is
//   followed by a one-cycle RELEASE gap with the bus request low.
//
//   Optional feature macro: CPU_BUS_ARB_ROUND_ROBIN_EN
//     defined   : simultaneous requests go to the port not granted last
//     undefined : simultaneous requests always go to the data port
//
// Ports
//   i_clock, i_reset              clock, synchronous active-high reset
//   i_i_request/i_i_address       fetch request and address
//   o_i_ready/o_i_rdata           fetch done pulse and data
//   i_d_request/i_d_rw/i_d_address/i_d_wdata
//                                 data request, direction, address, write data
//   o_d_ready/o_d_rdata           data done pulse and read data
//   o_bus_request/o_bus_rw/o_bus_address/o_bus_wdata
//                                 shared bus request side
//   i_bus_ready/i_bus_rdata       shared bus completion and read data
//   o_timeout                     one-cycle pulse on an aborted transaction
//
// Parameter
//   TIMEOUT_CYCLES  bus cycles without i_bus_ready before abort (0 = never)
module cpu_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_i_request,
  input  logic [31:0] i_i_address,
  output logic        o_i_ready,
  output logic [31:0] o_i_rdata,
  input  logic        i_d_request,
  input  logic        i_d_rw,
  input  logic [31:0] i_d_address,
  input  logic [31:0] i_d_wdata,
  output logic        o_d_ready,
  output logic [31:0] o_d_rdata,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata,
  output logic        o_timeout
);

  typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, RELEASE} state_t;

  // Keep the counter at least one bit wide when the timeout is disabled.
  localparam int            CW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          in_bus;
  logic          timeout_hit;
  logic          grant_d;

  assign in_bus = (state == BUS_I) || (state == BUS_D);

  // Completion in the same cycle as the limit wins over the abort.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_bus && !i_bus_ready && (cnt == TO_VAL);

`ifdef CPU_BUS_ARB_ROUND_ROBIN_EN
  logic last_d;  // 1 = data port had the most recent grant

  assign grant_d = i_d_request && (!i_i_request || !last_d);

  always_ff @(posedge i_clock) begin
    if (i_reset)
      last_d <= 1'b0;
    else if (state == IDLE && (i_i_request || i_d_request))
      last_d <= grant_d;
  end
`else
  assign grant_d = i_d_request;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      // Zero outside BUS_x so every grant starts counting from 0.
      if (in_bus && !i_bus_ready && !timeout_hit)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
    end
  end

  always_comb begin
    state_nxt     = state;
    o_i_ready     = 1'b0;
    o_i_rdata     = '0;
    o_d_ready     = 1'b0;
    o_d_rdata     = '0;
    o_bus_request = 1'b0;
    o_bus_rw      = 1'b0;
    o_bus_address = '0;
    o_bus_wdata   = '0;
    o_timeout     = 1'b0;

    case (state)
      IDLE: begin
        if (grant_d)          state_nxt = BUS_D;
        else if (i_i_request) state_nxt = BUS_I;
      end
      BUS_I: begin
        o_bus_request = 1'b1;
        o_bus_address = i_i_address;
        if (i_bus_ready) begin
          o_i_ready = 1'b1;
          o_i_rdata = i_bus_rdata;
          state_nxt = RELEASE;
        end else if (timeout_hit) begin
          o_i_ready = 1'b1;
          o_timeout = 1'b1;
          state_nxt = RELEASE;
        end
      end
      BUS_D: begin
        o_bus_request = 1'b1;
        o_bus_rw      = i_d_rw;
        o_bus_address = i_d_address;
        o_bus_wdata   = i_d_wdata;
        if (i_bus_ready) begin
          o_d_ready = 1'b1;
          o_d_rdata = i_bus_rdata;
          state_nxt = RELEASE;
        end else if (timeout_hit) begin
          o_d_ready = 1'b1;
          o_timeout = 1'b1;
          state_nxt = RELEASE;
        end
      end
      default: state_nxt = IDLE;  // RELEASE
    endcase

    // Outputs are forced quiet for the whole reset cycle, even if the state
    // register has not yet returned to IDLE.
    if (i_reset) begin
      state_nxt     = IDLE;
      o_i_ready     = 1'b0;
      o_i_rdata     = '0;
      o_d_ready     = 1'b0;
      o_d_rdata     = '0;
      o_bus_request = 1'b0;
      o_bus_rw      = 1'b0;
      o_bus_address = '0;
      o_bus_wdata   = '0;
      o_timeout     = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
module tb_cpu_bus_arbiter;

  localparam logic [31:0] I_ADDR = 32'h0000_0100;
  localparam logic [31:0] D_ADDR = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_i_request;
  logic [31:0] i_i_address;
  logic        o_i_ready;
  logic [31:0] o_i_rdata;
  logic        i_d_request, i_d_rw;
  logic [31:0] i_d_address, i_d_wdata;
  logic        o_d_ready;
  logic [31:0] o_d_rdata;
  logic        o_bus_request, o_bus_rw;
  logic [31:0] o_bus_address, o_bus_wdata;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;
  logic        o_timeout;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cpu_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .i_clock(clk), .i_reset(i_reset),
    .i_i_request(i_i_request), .i_i_address(i_i_address),
    .o_i_ready(o_i_ready), .o_i_rdata(o_i_rdata),
    .i_d_request(i_d_request), .i_d_rw(i_d_rw),
    .i_d_address(i_d_address), .i_d_wdata(i_d_wdata),
    .o_d_ready(o_d_ready), .o_d_rdata(o_d_rdata),
    .o_bus_request(o_bus_request), .o_bus_rw(o_bus_rw),
    .o_bus_address(o_bus_address), .o_bus_wdata(o_bus_wdata),
    .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata),
    .o_timeout(o_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to the next cycle; inputs changed after this belong to that cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Wait (bounded) for a grant, check who got it, complete it with bus ready.
  task automatic txn(input logic [31:0] exp_addr, input logic drop_d,
                     input logic drop_i, input string tag);
    int n = 0;
    while (o_bus_request !== 1'b1 && n < 6) begin
      tick();
      n++;
    end
    chk({tag, " grant"}, o_bus_address, exp_addr);
    i_bus_ready = 1'b1;
    i_bus_rdata = exp_addr ^ 32'hA5A5_0000;
    #1;
    chk({tag, " ready"}, (exp_addr == D_ADDR) ? o_d_ready : o_i_ready, 32'd1);
    chk({tag, " rdata"}, (exp_addr == D_ADDR) ? o_d_rdata : o_i_rdata,
        exp_addr ^ 32'hA5A5_0000);
    tick();
    i_bus_ready = 1'b0;
    if (drop_d) i_d_request = 1'b0;
    if (drop_i) i_i_request = 1'b0;
    #1;
    chk({tag, " release"}, o_bus_request, 32'd0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_i_request = 0; i_i_address = 0;
    i_d_request = 0; i_d_rw = 0; i_d_address = 0; i_d_wdata = 0;
    i_bus_ready = 0; i_bus_rdata = 0;

    // Reset: outputs quiet even with a request and bus ready present.
    tick();
    i_i_request = 1; i_bus_ready = 1; i_bus_rdata = 32'h1234; #1;
    tick();
    chk("rst bus_req", o_bus_request, 0);
    chk("rst i_ready", o_i_ready, 0);
    chk("rst timeout", o_timeout, 0);
    i_i_request = 0; i_bus_ready = 0; i_reset = 0;

    // Fetch only: request at cycle 0, ready at cycle 3.
    tick();                                         // cycle 0
    i_i_request = 1; i_i_address = 32'h100; #1;
    chk("f c0 bus_req", o_bus_request, 0);
    tick();                                         // cycle 1
    chk("f c1 bus_req", o_bus_request, 1);
    chk("f c1 addr", o_bus_address, 32'h100);
    chk("f c1 rw", o_bus_rw, 0);
    chk("f c1 i_rdata", o_i_rdata, 0);
    tick();                                         // cycle 2
    chk("f c2 bus_req", o_bus_request, 1);
    tick();                                         // cycle 3
    i_bus_ready = 1; i_bus_rdata = 32'h13; #1;
    chk("f c3 bus_req", o_bus_request, 1);
    chk("f c3 i_ready", o_i_ready, 1);
    chk("f c3 i_rdata", o_i_rdata, 32'h13);
    chk("f c3 d_ready", o_d_ready, 0);
    tick();                                         // cycle 4
    i_bus_ready = 0; i_i_request = 0; #1;
    chk("f c4 bus_req", o_bus_request, 0);
    chk("f c4 addr", o_bus_address, 0);
    chk("f c4 i_ready", o_i_ready, 0);

    // Data write.
    tick();
    i_d_request = 1; i_d_rw = 1; i_d_address = 32'h8000; i_d_wdata = 32'hCAFEF00D;
    i_bus_rdata = 32'h55; #1;
    tick();
    chk("w bus_req", o_bus_request, 1);
    chk("w rw", o_bus_rw, 1);
    chk("w addr", o_bus_address, 32'h8000);
    chk("w wdata", o_bus_wdata, 32'hCAFEF00D);
    chk("w d_rdata idle", o_d_rdata, 0);
    tick();
    i_bus_ready = 1; #1;
    chk("w d_ready", o_d_ready, 1);
    tick();
    i_bus_ready = 0; i_d_request = 0; i_d_rw = 0; #1;
    chk("w release wdata", o_bus_wdata, 0);
    chk("w release rw", o_bus_rw, 0);

    // Simultaneous requests: D first, then I.
    do_reset();
    i_i_address = I_ADDR; i_d_address = D_ADDR; i_d_wdata = 0;
    i_i_request = 1; i_d_request = 1; #1;
    txn(D_ADDR, 1'b1, 1'b0, "both D");
    txn(I_ADDR, 1'b0, 1'b1, "both I");

    // Both held for four transactions.
    i_i_request = 1; i_d_request = 1; #1;
`ifdef CPU_BUS_ARB_ROUND_ROBIN_EN
    txn(D_ADDR, 1'b0, 1'b0, "held1");
    txn(I_ADDR, 1'b0, 1'b0, "held2");
    txn(D_ADDR, 1'b0, 1'b0, "held3");
    txn(I_ADDR, 1'b1, 1'b1, "held4");
`else
    txn(D_ADDR, 1'b0, 1'b0, "held1");
    txn(D_ADDR, 1'b0, 1'b0, "held2");
    txn(D_ADDR, 1'b0, 1'b0, "held3");
    txn(D_ADDR, 1'b1, 1'b1, "held4");
`endif

    // Timeout: bus never ready; request dropped mid-transaction still completes.
    tick();
    i_d_request = 1; i_d_address = 32'h300; i_bus_rdata = 32'hDEAD; #1;
    tick();                                         // grant cycle, count 0
    chk("to grant", o_bus_request, 1);
    i_d_request = 0;
    for (int k = 1; k < 8; k++) tick();
    chk("to c7 timeout", o_timeout, 0);
    tick();                                         // grant + 8
    chk("to timeout", o_timeout, 1);
    chk("to d_ready", o_d_ready, 1);
    chk("to d_rdata", o_d_rdata, 0);
    tick();
    chk("to release", o_timeout, 0);
    chk("to release req", o_bus_request, 0);

    // Ready on the limit cycle: completion wins.
    tick();
    i_d_request = 1; #1;
    tick();
    for (int k = 1; k <= 8; k++) tick();
    i_bus_ready = 1; #1;
    chk("tie timeout", o_timeout, 0);
    chk("tie d_ready", o_d_ready, 1);
    chk("tie d_rdata", o_d_rdata, 32'hDEAD);
    tick();
    i_bus_ready = 0; i_d_request = 0; #1;

    // Reset while in BUS_I, data request pending.
    tick();
    i_i_request = 1; i_i_address = I_ADDR; #1;
    tick();
    chk("rb bus_i", o_bus_request, 1);
    i_reset = 1; i_d_request = 1; i_d_address = D_ADDR; i_bus_ready = 1; #1;
    chk("rb i_ready", o_i_ready, 0);
    chk("rb bus_req", o_bus_request, 0);
    tick();
    i_reset = 0; i_bus_ready = 0; i_i_request = 0; #1;
    chk("rb idle req", o_bus_request, 0);
    chk("rb idle i_ready", o_i_ready, 0);
    txn(D_ADDR, 1'b1, 1'b0, "rb data");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

endmodule
